// File: rtl/rv32im_lsu_wb_pkg.sv
// Shared types and encodings for the rv32im load/store unit.
package rv32im_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BUS      = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_BEAT2 = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_e;

  // Half at odd offset or word off a word boundary straddles a lane group.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rv32im_lsu_wb_if.sv
// Wishbone B4 pipelined master bus plus arbiter request/grant pair.
interface rv32im_lsu_wb_if #(parameter int XLEN = 32);
  // Request is valid while stb_o is high; it is taken on a cycle with stb_o & ~stall_i.
  // cyc_o frames the beat and stays high until ack_i or err_i ends it.
  logic [XLEN-1:0] master_dat_i;
  logic [XLEN-1:0] master_dat_o;
  logic [XLEN-3:0] adr_o;
  logic            cyc_o;
  logic            stb_o;
  logic            we_o;
  logic [3:0]      sel_o;
  logic            ack_i;
  logic            err_i;
  logic            stall_i;
  logic            ctrl_req_o;
  logic            ctrl_grant_i;

  modport master (
    input  master_dat_i, ack_i, err_i, stall_i, ctrl_grant_i,
    output master_dat_o, adr_o, cyc_o, stb_o, we_o, sel_o, ctrl_req_o
  );

  modport slave (
    output master_dat_i, ack_i, err_i, stall_i, ctrl_grant_i,
    input  master_dat_o, adr_o, cyc_o, stb_o, we_o, sel_o, ctrl_req_o
  );
endinterface

// File: rtl/rv32im_lsu_wb_align.sv
// Byte-lane alignment: sel mask, store shift over a 64-bit view, load extract/extend.
module rv32im_lsu_align
  import rv32im_lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_st_data,
  input  logic [63:0] i_ld_raw,
  output logic [7:0]  o_sel,
  output logic [63:0] o_st_data,
  output logic [31:0] o_ld_data
);

  logic [3:0]  w_mask;
  logic [4:0]  w_shamt;
  logic [31:0] w_ld_shift;

  always_comb begin
    case (i_size)
      SZ_BYTE: w_mask = 4'b0001;
      SZ_HALF: w_mask = 4'b0011;
      SZ_WORD: w_mask = 4'b1111;
      default: w_mask = 4'b1111;
    endcase
    w_shamt    = {i_off, 3'b000};
    o_sel      = {4'b0000, w_mask} << i_off;
    o_st_data  = {32'b0, i_st_data} << w_shamt;
    w_ld_shift = 32'(i_ld_raw >> w_shamt);
    case (i_size)
      SZ_BYTE: o_ld_data = {{24{~i_unsigned & w_ld_shift[7]}}, w_ld_shift[7:0]};
      SZ_HALF: o_ld_data = {{16{~i_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: o_ld_data = w_ld_shift;
    endcase
  end

endmodule

// File: rtl/rv32im_lsu_wb.sv
// Load/store unit: Wishbone pipelined master with lane alignment, split beats and timeout.
module rv32im_lsu_wb
  import rv32im_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int MISALIGN_SPLIT = 1,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clear_i,
  input  logic            req_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      word_size_i,
  input  logic            unsigned_i,
  input  logic            write_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [1:0]      err_cause_o,
  output lsu_state_e      state_o,
  rv32im_lsu_wb_if.master wb
);

  lsu_state_e      r_state, w_state_next;
  logic [XLEN-1:0] r_addr, r_wdata, r_buf_lo, r_data;
  logic [1:0]      r_size, r_cause;
  logic            r_unsigned, r_write, r_stb_sent, r_err;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_fail, w_last_ack, w_in_beat, w_to_hit, w_need_b2, w_stb;
  logic [1:0]      w_fail_cause;
  logic [7:0]      w_sel8;
  logic [63:0]     w_st64, w_ld_raw;
  logic [31:0]     w_ld_data;

  rv32im_lsu_align u_align (
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_st_data  (r_wdata),
    .i_ld_raw   (w_ld_raw),
    .o_sel      (w_sel8),
    .o_st_data  (w_st64),
    .o_ld_data  (w_ld_data)
  );

  assign w_need_b2 = |w_sel8[7:4];
  assign w_in_beat = (r_state == ST_BEAT1) || (r_state == ST_BEAT2);
  assign w_to_hit  = (TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  // The final ack's lanes are combined with beat-1 lanes captured earlier.
  assign w_ld_raw  = (r_state == ST_BEAT2) ? {wb.master_dat_i, r_buf_lo}
                                           : {32'b0, wb.master_dat_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     r_state <= ST_IDLE;
    else if (clear_i) r_state <= ST_IDLE;
    else              r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fail       = 1'b0;
    w_fail_cause = CAUSE_NONE;
    w_last_ack   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          if ((MISALIGN_SPLIT == 0) && is_misaligned(word_size_i, addr_i[1:0])) begin
            w_state_next = ST_RESP;
            w_fail       = 1'b1;
            w_fail_cause = CAUSE_MISALIGN;
          end else if (wb.ctrl_grant_i) begin
            w_state_next = ST_BEAT1;
          end else begin
            w_state_next = ST_ARB;
          end
        end
      end
      ST_ARB: if (wb.ctrl_grant_i) w_state_next = ST_BEAT1;
      ST_BEAT1, ST_BEAT2: begin
        if (wb.err_i) begin
          w_state_next = ST_RESP;
          w_fail       = 1'b1;
          w_fail_cause = CAUSE_BUS;
        end else if (wb.ack_i) begin
          if ((r_state == ST_BEAT1) && w_need_b2) begin
            w_state_next = ST_BEAT2;
          end else begin
            w_state_next = ST_RESP;
            w_last_ack   = 1'b1;
          end
        end else if (w_to_hit) begin
          w_state_next = ST_RESP;
          w_fail       = 1'b1;
          w_fail_cause = CAUSE_TIMEOUT;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stb           = w_in_beat && !r_stb_sent;
    wb.cyc_o        = w_in_beat;
    wb.stb_o        = w_stb;
    wb.we_o         = w_in_beat && r_write;
    wb.sel_o        = 4'b0000;
    wb.adr_o        = '0;
    wb.master_dat_o = '0;
    if (r_state == ST_BEAT1) begin
      wb.sel_o = w_sel8[3:0];
      wb.adr_o = r_addr[XLEN-1:2];
      if (r_write) wb.master_dat_o = w_st64[31:0];
    end else if (r_state == ST_BEAT2) begin
      wb.sel_o = w_sel8[7:4];
      wb.adr_o = r_addr[XLEN-1:2] + (XLEN-2)'(1);
      if (r_write) wb.master_dat_o = w_st64[63:32];
    end
    wb.ctrl_req_o = w_in_beat || (r_state == ST_ARB);
    busy_o        = w_in_beat || (r_state == ST_ARB);
    done_o        = (r_state == ST_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_addr <= '0; r_wdata <= '0; r_size <= SZ_BYTE; r_unsigned <= 1'b0; r_write <= 1'b0;
      r_stb_sent <= 1'b0; r_to_cnt <= '0; r_buf_lo <= '0; r_data <= '0;
      r_err <= 1'b0; r_cause <= CAUSE_NONE;
    end else if (clear_i) begin
      r_addr <= '0; r_wdata <= '0; r_size <= SZ_BYTE; r_unsigned <= 1'b0; r_write <= 1'b0;
      r_stb_sent <= 1'b0; r_to_cnt <= '0; r_buf_lo <= '0; r_data <= '0;
      r_err <= 1'b0; r_cause <= CAUSE_NONE;
    end else begin
      if ((r_state == ST_IDLE) && req_i) begin
        r_addr     <= addr_i;
        r_wdata    <= data_i;
        r_size     <= word_size_i;
        r_unsigned <= unsigned_i;
        r_write    <= write_i;
        r_err      <= 1'b0;
        r_cause    <= CAUSE_NONE;
      end
      if (w_fail) begin
        r_err   <= 1'b1;
        r_cause <= w_fail_cause;
      end
      // Every state change starts a fresh beat: re-arm strobe and timeout.
      if (r_state != w_state_next) begin
        r_stb_sent <= 1'b0;
        r_to_cnt   <= '0;
      end else begin
        if (w_stb && !wb.stall_i) r_stb_sent <= 1'b1;
        if (w_in_beat)            r_to_cnt   <= r_to_cnt + TO_W'(1);
      end
      if ((r_state == ST_BEAT1) && wb.ack_i && !wb.err_i) r_buf_lo <= wb.master_dat_i;
      if (w_last_ack && !r_write) r_data <= w_ld_data;
    end
  end

  assign data_o      = r_data;
  assign err_o       = r_err;
  assign err_cause_o = r_cause;
  assign state_o     = r_state;

endmodule

// File: doc/rv32im_lsu_wb.md
Name: rv32im_lsu_wb

Overview:
Parametrised load/store unit for the rv32im core. It replaces the single-beat memory stage with a Wishbone B4 pipelined master. The block provides true byte-lane alignment, sign/zero extension, optional splitting of misaligned accesses into two bus beats, bus-grant arbitration and a transaction timeout. It sits between the execute stage and the shared Wishbone interconnect.

Parameters:
XLEN, 32, data/address width; only 32 is supported (4 byte lanes).
MISALIGN_SPLIT, 1, 1 = misaligned accesses are split into two beats; 0 = misaligned accesses raise an error.
TIMEOUT_CYCLES, 16, cycles of cyc_o without ack/err before abort; 0 disables the timeout.
TO_W, 5, width of the timeout counter; must be at least clog2(TIMEOUT_CYCLES+1).

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
rst_n_i  in  1  reset, asynchronous, active-low.
clear_i  in  1  synchronous flush; same effect as reset.
req_i  in  1  access request, sampled in IDLE only.
addr_i  in  XLEN  byte address.
data_i  in  XLEN  store data, LSB-aligned.
word_size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
unsigned_i  in  1  load: zero-extend when 1, sign-extend when 0.
write_i  in  1  1 = store.
data_o  out  XLEN  load result, extended and LSB-aligned.
busy_o  out  1  high from acceptance until done_o.
done_o  out  1  one-cycle completion pulse; also pulses on error.
err_o  out  1  sticky error flag; cleared on the next accepted req_i.
err_cause_o  out  2  00 none, 01 bus err_i, 10 misaligned, 11 timeout.
master_dat_i  in  XLEN  Wishbone read data.
master_dat_o  out  XLEN  Wishbone write data, lane-shifted.
adr_o  out  XLEN-2  word address.
cyc_o  out  1  Wishbone cycle.
stb_o  out  1  Wishbone strobe.
we_o  out  1  Wishbone write enable.
sel_o  out  4  Wishbone byte lanes.
ack_i  in  1  Wishbone acknowledge.
err_i  in  1  Wishbone error.
stall_i  in  1  Wishbone pipelined stall.
ctrl_req_o  out  1  bus request to the arbiter.
ctrl_grant_i  in  1  bus grant from the arbiter.

Behaviour:
- Reset values (asynchronous on rst_n_i low, or synchronous on clear_i): all outputs 0; state IDLE; timeout counter 0. A reset or clear mid-transaction drops cyc/stb/ctrl_req immediately, with no done_o.
- States: IDLE, ARB, BEAT1, BEAT2, RESP.
- IDLE with req_i high:
  - Latch addr, size, unsigned, write and data; set busy_o.
  - Misaligned means half at offset 1 or 3, or word at offset not 0.
  - Misaligned with MISALIGN_SPLIT=0: go to RESP with cause 10; no bus activity.
  - Otherwise raise ctrl_req_o; go to BEAT1 if ctrl_grant_i is already high, else ARB.
- ARB: wait for ctrl_grant_i, then BEAT1.
- BEAT1 and BEAT2 handshake:
  - Assert cyc_o and stb_o with adr, sel and we.
  - stb_o is held while stall_i is high.
  - stb_o drops the cycle after stb & ~stall; cyc_o stays high until ack_i or err_i.
  - Grant loss mid-beat is ignored; the arbiter must not revoke while cyc_o is high.
- Lane and sel rules:
  - sel = size mask << addr[1:0].
  - The lower 4 bits of sel go to BEAT1 at adr = addr[31:2].
  - The overflow bits [7:4] go to BEAT2 at adr = addr[31:2]+1; the adr+1 increment wraps mod 2^30.
  - BEAT2 happens only if the overflow is non-zero.
  - Store data is shifted left by 8×offset across a 64-bit view; beat N drives the corresponding 32-bit half.
- Load assembly: collect the selected lanes from each ack into a 64-bit buffer, shift right by 8×offset, then sign- or zero-extend by size.
- ack_i on the final beat: go to RESP. data_o and done_o are valid in the RESP cycle, which is 1 cycle after the last ack. Then cyc_o and ctrl_req_o drop and the block returns to IDLE.
- err_i during a beat (with cyc high): abort, cause 01, go to RESP; BEAT2 is skipped. err_i has priority over a simultaneous ack_i.
- Timeout:
  - Counter resets at every beat start and counts cycles with cyc_o high.
  - Reaching TIMEOUT_CYCLES aborts with cause 11; cyc and stb drop in the same cycle as entry to RESP.
  - ack_i in the same cycle as the timeout is taken as success.
- RESP: done_o=1 and busy_o drops in that cycle. data_o holds until the next load completes; it is unchanged on stores and errors.
- req_i outside IDLE is ignored.
- Minimum latency, aligned access with grant held: req at cycle 0, stb at cycle 1, ack at cycle 1, done at cycle 2.

Decomposition:
- Package rv32im_lsu_pkg:
  - Size encodings (SZ_BYTE/SZ_HALF/SZ_WORD).
  - Err cause constants.
  - State enum.
- Sub-module rv32im_lsu_align, combinational: offset + size → 8-bit sel mask, 64-bit store shift, load extract and extend. It is reused by the future cache path.

Test Plan:
- LW at 0x100, grant high, ack next cycle, dat 0xDEADBEEF → sel 1111, adr 0x40, data_o=0xDEADBEEF, done at cycle 2.
- LB at 0x103, dat 0x80FFFFFF → sel 1000; data_o=0xFFFFFF80; with unsigned_i=1, data_o=0x00000080.
- SW 0x11223344 at 0x102, SPLIT=1 → beat1 adr 0x40 sel 1100 dat 0x33440000; beat2 adr 0x41 sel 0011 dat 0x00001122; one done.
- LH at 0x003, SPLIT=0 → no cyc, done with err_o=1, cause 10; next aligned req clears err_o.
- stall_i for 3 cycles, then ack → stb held 3 cycles, then completes; no timeout with TIMEOUT_CYCLES=16.
- No ack for 16 cycles → cyc drops, cause 11. Then err_i during beat1 of a split access → cause 01, BEAT2 never issued. Then rst_n_i low mid-beat → all outputs 0 asynchronously.
